// File: rtl/sodor_instr_stream_gen.sv
// -----------------------------------------------------------------------------
// sodor_instr_stream_gen
//
// Seeded random RV32I instruction-stream source. It feeds the imem response
// data of a Sodor5 core and of its reference model with the same word
// sequence. The generator emits `count` instructions per run over a
// valid/ready handshake. Each word is drawn from up to four instruction
// classes (ALU-I, load, store, R-type), selected by a runtime enable mask.
//
// Optional feature (compile-time macro SODOR_GEN_HAZARD_EN):
//   Remembers the rd of the last accepted ALU-I, load or R-type word. When
//   LFSR bit 27 is set, it substitutes that rd for rs1, which forces a
//   read-after-write hazard on the very next instruction.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      one-cycle run request, sampled only while idle
//   count      in   CNT_W  instructions in the run, latched on start
//   class_en   in   4      bit0 ALU-I, bit1 load, bit2 store, bit3 R-type
//   out_valid  out  1      out_instr carries a generated instruction
//   out_ready  in   1      consumer accepts the current word
//   out_instr  out  32     instruction word (NOP while out_valid=0)
//   busy       out  1      run in progress
//   done       out  1      one-cycle pulse after the last accepted word
//   issued     out  CNT_W  words accepted in the current run
// -----------------------------------------------------------------------------
module sodor_instr_stream_gen #(
  parameter logic [31:0] SEED        = 32'h0000_034D,
  parameter int          CNT_W       = 16,
  parameter logic [4:0]  REG_MASK    = 5'h1F,
  parameter logic [11:0] LD_IMM_MASK = 12'hFFF,
  parameter logic [2:0]  LD_F3_MASK  = 3'b100,
  parameter logic [31:0] NOP         = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [3:0]       class_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued
);

  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;
  // An all-zero seed would lock the LFSR, so it is replaced with 1.
  localparam logic [31:0]      SEED_EFF  = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_LD  = 2'd1;
  localparam logic [1:0] CLS_ST  = 2'd2;
  localparam logic [1:0] CLS_R   = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Eight Galois steps per accepted word, so consecutive words share no
  // overlapping field bits from a single shift.
  function automatic logic [31:0] lfsr_step8(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      if (t[0]) begin
        t = (t >> 1) ^ LFSR_TAPS;
      end else begin
        t = t >> 1;
      end
    end
    return t;
  endfunction

  // Start at the random pick and rotate upward to the first enabled class.
  function automatic logic [1:0] pick_class(input logic [1:0] sel, input logic [3:0] en);
    logic [1:0] c;
    logic [1:0] r;
    logic       found;
    r     = CLS_ALU;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c = sel + k[1:0];
      if (!found && en[c]) begin
        r     = c;
        found = 1'b1;
      end else begin
        r     = r;
        found = found;
      end
    end
    return r;
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  logic [31:0]      r_lfsr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_issued;
  logic [3:0]       r_cls_en;
  logic             r_done;

  logic             w_run;
  logic             w_accept;
  logic             w_last;
  logic             w_latch;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_issued_inc;

  logic [11:0]      w_imm;
  logic [4:0]       w_rs1_raw;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rd;
  logic [2:0]       w_f3;
  logic [1:0]       w_sel;
  logic [4:0]       w_rs2;
  logic [1:0]       w_cls;
  logic [11:0]      w_ld_imm;
  logic [11:0]      w_alu_imm;
  logic [2:0]       w_f3s;
  logic [6:0]       w_f7;
  logic [31:0]      w_enc;

  assign w_run        = (r_state == ST_RUN);
  assign w_accept     = w_run & out_ready;
  assign w_issued_inc = r_issued + CNT_ONE;
  assign w_last       = (w_issued_inc == r_count);

  // Raw fields from the current LFSR state.
  assign w_imm     = r_lfsr[11:0];
  assign w_rs1_raw = r_lfsr[16:12] & REG_MASK;
  assign w_rd      = r_lfsr[21:17] & REG_MASK;
  assign w_f3      = r_lfsr[24:22];
  assign w_sel     = r_lfsr[26:25];
  assign w_rs2     = r_lfsr[31:27] & REG_MASK;
  assign w_cls     = pick_class(w_sel, r_cls_en);

`ifdef SODOR_GEN_HAZARD_EN
  logic [4:0] r_last_rd;

  assign w_rs1 = r_lfsr[27] ? r_last_rd : w_rs1_raw;

  // Track the destination of the last accepted register-writing word (stores excluded).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_rd <= 5'd0;
    end else if (w_accept && (w_cls != CLS_ST)) begin
      r_last_rd <= w_rd;
    end else begin
      r_last_rd <= r_last_rd;
    end
  end
`else
  assign w_rs1 = w_rs1_raw;
`endif

  // Instruction encoder for the class picked from the current LFSR state.
  always_comb begin
    w_ld_imm  = w_imm & LD_IMM_MASK;
    w_alu_imm = w_imm;
    w_f3s     = {1'b0, w_f3[1:0]};
    w_f7      = 7'h00;
    w_enc     = NOP;

    // Shifts carry a 5-bit shamt; SRAI keeps bit 10 to distinguish it from SRLI.
    case (w_f3)
      3'd1:    w_alu_imm = w_imm & 12'h01F;
      3'd5:    w_alu_imm = w_imm & 12'h41F;
      default: w_alu_imm = w_imm;
    endcase

    // funct3 3 (SD) is not RV32I, so it folds onto SW.
    if (w_f3[1:0] == 2'b11) begin
      w_f3s = 3'b010;
    end else begin
      w_f3s = {1'b0, w_f3[1:0]};
    end

    // SUB and SRA are the only R-type forms that use funct7 = 0x20.
    if (w_imm[11] && ((w_f3 == 3'd0) || (w_f3 == 3'd5))) begin
      w_f7 = 7'h20;
    end else begin
      w_f7 = 7'h00;
    end

    case (w_cls)
      CLS_ALU: w_enc = {w_alu_imm, w_rs1, w_f3, w_rd, 7'h13};
      CLS_LD:  w_enc = {w_ld_imm, w_rs1, w_f3 & LD_F3_MASK, w_rd, 7'h03};
      CLS_ST:  w_enc = {w_ld_imm[11:5], w_rs2, w_rs1, w_f3s, w_ld_imm[4:0], 7'h23};
      CLS_R:   w_enc = {w_f7, w_rs2, w_rs1, w_f3, w_rd, 7'h33};
      default: w_enc = NOP;
    endcase
  end

  // Next-state and control decode for the run FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (count != CNT_ZERO)) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (start) begin
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_accept && w_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run configuration and accepted-word counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= CNT_ZERO;
      r_cls_en <= 4'b0001;
      r_issued <= CNT_ZERO;
    end else if (w_latch) begin
      r_count  <= count;
      r_cls_en <= (class_en == 4'b0000) ? 4'b0001 : class_en;
      r_issued <= CNT_ZERO;
    end else if (w_accept) begin
      r_count  <= r_count;
      r_cls_en <= r_cls_en;
      r_issued <= w_issued_inc;
    end else begin
      r_count  <= r_count;
      r_cls_en <= r_cls_en;
      r_issued <= r_issued;
    end
  end

  // LFSR advances only on accept and survives across runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED_EFF;
    end else if (w_accept) begin
      r_lfsr <= lfsr_step8(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  // Done pulse register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
    end
  end

  assign out_valid = w_run;
  assign busy      = w_run;
  assign out_instr = w_run ? w_enc : NOP;
  assign done      = r_done;
  assign issued    = r_issued;

endmodule

// File: tb/tb_sodor_instr_stream_gen.sv
// Self-checking bench for sodor_instr_stream_gen: directed runs compared
// against hand-derived first words and a small independent stream model.
module tb_sodor_instr_stream_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] count;
  logic [3:0]  class_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        busy;
  logic        done;
  logic [15:0] issued;

  int n_checks;
  int n_pass;

  logic [31:0] m_lfsr;
  logic [4:0]  m_last_rd;

  sodor_instr_stream_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .count     (count),
    .class_en  (class_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .busy      (busy),
    .done      (done),
    .issued    (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_step8(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    repeat (8) t = t[0] ? ((t >> 1) ^ 32'h8020_0003) : (t >> 1);
    return t;
  endfunction

  function automatic logic [1:0] m_class(input logic [31:0] s, input logic [3:0] en);
    logic [3:0] e;
    int         base;
    int         pick;
    e    = (en == 4'b0000) ? 4'b0001 : en;
    base = int'(s[26:25]);
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      if (pick < 0 && e[(base + k) % 4]) pick = (base + k) % 4;
    end
    return pick[1:0];
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] s, input logic [1:0] cls,
                                         input logic [4:0] last_rd);
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  f3s;
    logic [6:0]  f7;
    imm = s[11:0];
    rs1 = s[16:12];
`ifdef SODOR_GEN_HAZARD_EN
    if (s[27]) rs1 = last_rd;
`else
    if (last_rd == 5'd31 && 1'b0) rs1 = last_rd;
`endif
    rd  = s[21:17];
    f3  = s[24:22];
    rs2 = s[31:27];
    case (cls)
      2'd0: begin
        if (f3 == 3'd1) imm = {7'b0000000, imm[4:0]};
        else if (f3 == 3'd5) imm = {1'b0, imm[10], 5'b00000, imm[4:0]};
        return {imm, rs1, f3, rd, 7'h13};
      end
      2'd1: return {imm, rs1, f3[2], 2'b00, rd, 7'h03};
      2'd2: begin
        f3s = (f3[1:0] == 2'b11) ? 3'b010 : {1'b0, f3[1:0]};
        return {imm[11:5], rs2, rs1, f3s, imm[4:0], 7'h23};
      end
      default: begin
        f7 = (s[11] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
    endcase
  endfunction

  // Expected word for the model's current state, then advance as on accept.
  task automatic m_next(input logic [3:0] en, output logic [31:0] exp);
    logic [1:0] c;
    c   = m_class(m_lfsr, en);
    exp = m_word(m_lfsr, c, m_last_rd);
    if (c != 2'd2) m_last_rd = m_lfsr[21:17];
    m_lfsr = m_step8(m_lfsr);
  endtask

  task automatic pulse_start(input logic [15:0] cnt, input logic [3:0] en);
    @(negedge clk);
    start    = 1'b1;
    count    = cnt;
    class_en = en;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n   = 1'b1;
    m_lfsr    = 32'h0000_034D;
    m_last_rd = 5'd0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_instr !== 32'h0000_0013) $display("FAIL reset_instr: got %h want 00000013", out_instr); else n_pass++;
    n_checks++; if (issued !== 16'd0) $display("FAIL reset_issued: got %0d want 0", issued); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy, done); else n_pass++;
    n_checks++; if (dut.r_lfsr !== 32'h0000_034D) $display("FAIL reset_lfsr: got %h want 0000034d", dut.r_lfsr); else n_pass++;
  endtask

  task automatic test_alu_basic;
    int nv, nd;
    logic [31:0] exp;
    nv = 0; nd = 0;
    out_ready = 1'b1;
    pulse_start(16'd4, 4'b0001);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (out_valid) begin
        m_next(4'b0001, exp);
        if (nv == 0) begin
          n_checks++; if (out_instr !== 32'h34D0_0013) $display("FAIL alu_word0: got %h want 34d00013", out_instr); else n_pass++;
        end
        if (nv == 1) begin
          n_checks++; if (out_instr !== 32'h000E_4A93) $display("FAIL alu_word1: got %h want 000e4a93", out_instr); else n_pass++;
        end
        n_checks++; if (out_instr !== exp) $display("FAIL alu_word%0d: got %h want %h", nv, out_instr, exp); else n_pass++;
        n_checks++; if (out_instr[6:0] !== 7'h13) $display("FAIL alu_opcode%0d: got %h want 13", nv, out_instr[6:0]); else n_pass++;
        nv++;
      end
      if (done) begin
        nd++;
        n_checks++; if (busy !== 1'b0) $display("FAIL alu_busy_at_done: got %b want 0", busy); else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++; if (nv != 4) $display("FAIL alu_nvalid: got %0d want 4", nv); else n_pass++;
    n_checks++; if (nd != 1) $display("FAIL alu_ndone: got %0d want 1", nd); else n_pass++;
    n_checks++; if (issued !== 16'd4) $display("FAIL alu_issued: got %0d want 4", issued); else n_pass++;
  endtask

  task automatic test_backpressure;
    int acc, stall, nd;
    logic [31:0] exp, held_w, held_l;
    logic [15:0] held_i;
    acc = 0; stall = 0; nd = 0;
    held_w = 32'h0; held_l = 32'h0; held_i = 16'h0;
    out_ready = 1'b1;
    pulse_start(16'd6, 4'b1111);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid) begin
        if (acc == 2 && stall < 3) begin
          if (stall == 0) begin
            held_w = out_instr; held_l = dut.r_lfsr; held_i = issued;
            n_checks++; if (dut.r_lfsr !== m_lfsr) $display("FAIL bp_lfsr_pre: got %h want %h", dut.r_lfsr, m_lfsr); else n_pass++;
          end else begin
            n_checks++; if (out_instr !== held_w) $display("FAIL bp_hold_instr: got %h want %h", out_instr, held_w); else n_pass++;
            n_checks++; if (dut.r_lfsr !== held_l) $display("FAIL bp_hold_lfsr: got %h want %h", dut.r_lfsr, held_l); else n_pass++;
            n_checks++; if (issued !== held_i) $display("FAIL bp_hold_issued: got %0d want %0d", issued, held_i); else n_pass++;
          end
          out_ready = 1'b0;
          stall++;
        end else begin
          m_next(4'b1111, exp);
          n_checks++; if (out_instr !== exp) $display("FAIL bp_word%0d: got %h want %h", acc, out_instr, exp); else n_pass++;
          out_ready = 1'b1;
          acc++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) nd++;
      @(negedge clk);
    end
    n_checks++; if (acc != 6 || nd != 1) $display("FAIL bp_count: got acc=%0d done=%0d want 6/1", acc, nd); else n_pass++;
    n_checks++; if (issued !== 16'd6) $display("FAIL bp_issued: got %0d want 6", issued); else n_pass++;
  endtask

  task automatic test_mix_1000;
    int nv, nd, bad_model, bad_sh, bad_ld, bad_st;
    logic [3:0] seen;
    logic [31:0] exp;
    nv = 0; nd = 0; bad_model = 0; bad_sh = 0; bad_ld = 0; bad_st = 0; seen = 4'b0000;
    out_ready = 1'b1;
    pulse_start(16'd1000, 4'b1111);
    for (int cyc = 0; cyc < 1100 && nd == 0; cyc++) begin
      if (out_valid) begin
        m_next(4'b1111, exp);
        if (out_instr !== exp) begin
          bad_model++;
          if (bad_model < 5) $display("FAIL mix_word%0d: got %h want %h", nv, out_instr, exp);
        end
        case (out_instr[6:0])
          7'h13: begin
            seen[0] = 1'b1;
            if (out_instr[14:12] == 3'd1 && out_instr[31:25] != 7'h00) bad_sh++;
            if (out_instr[14:12] == 3'd5 && out_instr[31:25] != 7'h00 && out_instr[31:25] != 7'h20) bad_sh++;
          end
          7'h03: begin
            seen[1] = 1'b1;
            if (out_instr[14:12] != 3'd0 && out_instr[14:12] != 3'd4) bad_ld++;
          end
          7'h23: begin
            seen[2] = 1'b1;
            if (out_instr[14:12] == 3'd3) bad_st++;
          end
          7'h33: seen[3] = 1'b1;
          default: bad_model++;
        endcase
        nv++;
      end
      if (done) nd++;
      @(negedge clk);
    end
    n_checks++; if (bad_model != 0) $display("FAIL mix_model: got %0d bad words want 0", bad_model); else n_pass++;
    n_checks++; if (bad_sh != 0) $display("FAIL mix_shift_f7: got %0d bad want 0", bad_sh); else n_pass++;
    n_checks++; if (bad_ld != 0) $display("FAIL mix_load_f3: got %0d bad want 0", bad_ld); else n_pass++;
    n_checks++; if (bad_st != 0) $display("FAIL mix_store_f3: got %0d bad want 0", bad_st); else n_pass++;
    n_checks++; if (seen !== 4'b1111) $display("FAIL mix_opcodes_seen: got %b want 1111", seen); else n_pass++;
    n_checks++; if (nv != 1000 || nd != 1) $display("FAIL mix_count: got %0d words done=%0d want 1000/1", nv, nd); else n_pass++;
    n_checks++; if (issued !== 16'd1000) $display("FAIL mix_issued: got %0d want 1000", issued); else n_pass++;
  endtask

  task automatic test_class_zero;
    int nv, nd;
    logic [31:0] exp;
    nv = 0; nd = 0;
    out_ready = 1'b1;
    @(negedge clk);
    pulse_start(16'd8, 4'b0000);
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (out_valid) begin
        m_next(4'b0000, exp);
        n_checks++; if (out_instr[6:0] !== 7'h13) $display("FAIL cz_opcode%0d: got %h want 13", nv, out_instr[6:0]); else n_pass++;
        n_checks++; if (out_instr !== exp) $display("FAIL cz_word%0d: got %h want %h", nv, out_instr, exp); else n_pass++;
        nv++;
      end
      if (done) nd++;
      @(negedge clk);
    end
    n_checks++; if (nv != 8 || nd != 1) $display("FAIL cz_count: got %0d words done=%0d want 8/1", nv, nd); else n_pass++;
    // Zero-length run: done pulses, nothing is issued.
    pulse_start(16'd0, 4'b0001);
    n_checks++; if (done !== 1'b1) $display("FAIL cnt0_done: got %b want 1", done); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL cnt0_valid: got %b%b want 00", out_valid, busy); else n_pass++;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || done !== 1'b0) $display("FAIL cnt0_after%0d: got valid=%b done=%b want 0/0", cyc, out_valid, done); else n_pass++;
    end
  endtask

  task automatic test_reset_midrun;
    int acc, nd;
    logic [31:0] exp;
    acc = 0; nd = 0;
    out_ready = 1'b1;
    pulse_start(16'd10, 4'b0001);
    for (int cyc = 0; cyc < 6 && acc < 2; cyc++) begin
      if (out_valid) begin
        m_next(4'b0001, exp);
        n_checks++; if (out_instr !== exp) $display("FAIL mr_word%0d: got %h want %h", acc, out_instr, exp); else n_pass++;
        acc++;
      end
      @(negedge clk);
    end
    n_checks++; if (issued !== 16'd2) $display("FAIL mr_issued_pre: got %0d want 2", issued); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mr_valid: got %b%b want 00", out_valid, busy); else n_pass++;
    n_checks++; if (out_instr !== 32'h0000_0013) $display("FAIL mr_instr: got %h want 00000013", out_instr); else n_pass++;
    n_checks++; if (issued !== 16'd0) $display("FAIL mr_issued: got %0d want 0", issued); else n_pass++;
    n_checks++; if (dut.r_lfsr !== 32'h0000_034D) $display("FAIL mr_lfsr: got %h want 0000034d", dut.r_lfsr); else n_pass++;
    m_lfsr    = 32'h0000_034D;
    m_last_rd = 5'd0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (cyc == 1) reset_n = 1'b1;
      n_checks++; if (done !== 1'b0) $display("FAIL mr_no_done%0d: got %b want 0", cyc, done); else n_pass++;
    end
    pulse_start(16'd1, 4'b0001);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mr_restart_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_instr !== 32'h34D0_0013) $display("FAIL mr_restart_word: got %h want 34d00013", out_instr); else n_pass++;
    m_next(4'b0001, exp);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_checks++; if (nd != 1) $display("FAIL mr_restart_done: got %0d want 1", nd); else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    count     = 16'd0;
    class_en  = 4'b0000;
    out_ready = 1'b0;
    m_lfsr    = 32'h0000_034D;
    m_last_rd = 5'd0;
    test_reset();
    test_alu_basic();
    test_backpressure();
    test_mix_1000();
    test_class_zero();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
